// File: rtl/sys_defs.sv
// Shared bus encodings, tag record and lane helpers
// for the tagged memory model.
package sys_defs;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic             busy;
    logic             is_load;
    logic [CNT_W-1:0] count;
    logic [63:0]      data;
  } tag_rec_t;

  // Zero-extended read of the addressed lane.
  function automatic logic [63:0] lane_rd(
    input logic [63:0] line,
    input MEM_SIZE     sz,
    input logic [2:0]  off
  );
    logic [63:0] r;
    r = '0;
    unique case (sz)
      BYTE:   r = 64'(line[{off, 3'b000} +: 8]);
      HALF:   r = 64'(line[{off[2:1], 4'b0000} +: 16]);
      WORD:   r = 64'(line[{off[2], 5'b00000} +: 32]);
      DOUBLE: r = line;
    endcase
    return r;
  endfunction

  // Merge low bits of wdata into the addressed lane.
  function automatic logic [63:0] lane_wr(
    input logic [63:0] line,
    input logic [63:0] wdata,
    input MEM_SIZE     sz,
    input logic [2:0]  off
  );
    logic [63:0] m;
    m = line;
    unique case (sz)
      BYTE:   m[{off, 3'b000} +: 8] = wdata[7:0];
      HALF:   m[{off[2:1], 4'b0000} +: 16] = wdata[15:0];
      WORD:   m[{off[2], 5'b00000} +: 32] = wdata[31:0];
      DOUBLE: m = wdata;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_tag_pick.sv
// Lowest-index priority picker; bit i-1 is tag i,
// output 0 when no bit is set.
module mem_tag_pick #(
  parameter  int N = 15,
  localparam int W = $clog2(N + 1)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx_o = '0;
    for (int i = N; i >= 1; i--) begin
      if (req_i[i-1]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/tagged_mem.sv
// Tagged 64-bit memory with per-request latency
// and out-of-order, lowest-tag-first returns.
module tagged_mem
  import sys_defs::*;
#(
  parameter  int NUM_TAGS  = 15,
  parameter  int LINES     = 8192,
  parameter  int LAT_W     = 8,
  parameter  int STORE_ACK = 0,
  localparam int TAG_W     = $clog2(NUM_TAGS + 1),
  localparam int ADDR_W    = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] proc2mem_addr,
  input  logic [63:0]       proc2mem_data,
  input  MEM_SIZE           proc2mem_size,
  input  BUS_COMMAND        proc2mem_command,
  input  logic [LAT_W-1:0]  mem_latency,
  output logic [TAG_W-1:0]  mem2proc_response,
  output logic [63:0]       mem2proc_data,
  output logic [TAG_W-1:0]  mem2proc_tag,
  output logic              mem2proc_err
);

  localparam int LINE_W = $clog2(LINES);
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W + 1)'(LINES) << 3;

  logic [63:0]      mem_q [LINES];
  tag_rec_t         tags_q [NUM_TAGS:1];
  logic [TAG_W-1:0] resp_q, rtag_q;
  logic [63:0]      rdata_q;
  logic             err_q;

  logic [LINE_W-1:0] idx;
  logic [2:0]        off;
  logic              is_req, is_st, aligned;
  logic              in_range, valid, accept;
  logic [NUM_TAGS-1:0] free_v, exp_v;
  logic [TAG_W-1:0]  alloc_tag, ret_tag;
  logic [63:0]       ret_data, ld_data;
  logic [CNT_W-1:0]  lat_eff;

  assign idx      = proc2mem_addr[3 +: LINE_W];
  assign off      = proc2mem_addr[2:0];
  assign is_st    = proc2mem_command == BUS_STORE;
  assign is_req   = is_st
                 || proc2mem_command == BUS_LOAD;
  assign in_range = {1'b0, proc2mem_addr} < LIMIT;
  assign valid    = is_req && in_range && aligned;
  assign accept   = valid && alloc_tag != '0;
  assign lat_eff  = (mem_latency == '0)
                  ? CNT_W'(1) : CNT_W'(mem_latency);
  assign ld_data  = lane_rd(mem_q[idx],
                            proc2mem_size, off);

  // Natural alignment by access size.
  always_comb begin
    aligned = 1'b0;
    unique case (proc2mem_size)
      BYTE:   aligned = 1'b1;
      HALF:   aligned = ~off[0];
      WORD:   aligned = off[1:0] == 2'b00;
      DOUBLE: aligned = off == 3'b000;
    endcase
  end

  // Free and return-eligible vectors; a tag becomes
  // returnable at the edge its countdown reaches 0.
  always_comb begin
    free_v   = '0;
    exp_v    = '0;
    ret_data = '0;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      free_v[t-1] = ~tags_q[t].busy;
      exp_v[t-1]  = tags_q[t].busy
                 && tags_q[t].count <= CNT_W'(1)
                 && (tags_q[t].is_load
                     || STORE_ACK != 0);
      if (ret_tag == TAG_W'(t))
        ret_data = tags_q[t].data;
    end
  end

  mem_tag_pick #(.N(NUM_TAGS)) u_alloc (
    .req_i (free_v),
    .idx_o (alloc_tag)
  );

  mem_tag_pick #(.N(NUM_TAGS)) u_ret (
    .req_i (exp_v),
    .idx_o (ret_tag)
  );

  // Tag table, countdowns and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q  <= '0;
      rtag_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int t = 1; t <= NUM_TAGS; t++)
        tags_q[t] <= '0;
    end else begin
      resp_q  <= accept ? alloc_tag : '0;
      err_q   <= is_req && !valid;
      rtag_q  <= ret_tag;
      rdata_q <= ret_data;
      for (int t = 1; t <= NUM_TAGS; t++) begin
        if (tags_q[t].busy) begin
          if (tags_q[t].count != '0)
            tags_q[t].count <=
              tags_q[t].count - CNT_W'(1);
          if (ret_tag == TAG_W'(t))
            tags_q[t].busy <= 1'b0;
          else if (!tags_q[t].is_load
                   && STORE_ACK == 0
                   && tags_q[t].count <= CNT_W'(1))
            tags_q[t].busy <= 1'b0;
        end
        if (accept && alloc_tag == TAG_W'(t))
          tags_q[t] <= '{
            busy:    1'b1,
            is_load: ~is_st,
            count:   lat_eff,
            data:    is_st ? 64'd0 : ld_data
          };
      end
    end
  end

  // Backing store; writes land at the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++)
        mem_q[i] <= '0;
    end else if (accept && is_st) begin
      mem_q[idx] <= lane_wr(mem_q[idx],
                            proc2mem_data,
                            proc2mem_size, off);
    end
  end

  assign mem2proc_response = resp_q;
  assign mem2proc_tag      = rtag_q;
  assign mem2proc_data     = rdata_q;
  assign mem2proc_err      = err_q;

endmodule

// File: tb/tb_tagged_mem.sv
// Directed bench: two instances differing only in
// STORE_ACK share one stimulus stream.
module tb_tagged_mem;
  import sys_defs::*;

  localparam int NT = 15;
  localparam int LN = 8192;
  localparam int TW = $clog2(NT + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  MEM_SIZE     size = DOUBLE;
  BUS_COMMAND  cmd = BUS_NONE;
  logic [7:0]  lat = '0;

  logic [TW-1:0] resp0, tag0, resp1, tag1;
  logic [63:0]   data0, data1;
  logic          err0, err1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tagged_mem #(.NUM_TAGS(NT), .LINES(LN),
               .LAT_W(8), .STORE_ACK(0)) u0 (
    .clk (clk), .rst (rst),
    .proc2mem_addr (addr),
    .proc2mem_data (wdata),
    .proc2mem_size (size),
    .proc2mem_command (cmd),
    .mem_latency (lat),
    .mem2proc_response (resp0),
    .mem2proc_data (data0),
    .mem2proc_tag (tag0),
    .mem2proc_err (err0)
  );

  tagged_mem #(.NUM_TAGS(NT), .LINES(LN),
               .LAT_W(8), .STORE_ACK(1)) u1 (
    .clk (clk), .rst (rst),
    .proc2mem_addr (addr),
    .proc2mem_data (wdata),
    .proc2mem_size (size),
    .proc2mem_command (cmd),
    .mem_latency (lat),
    .mem2proc_response (resp1),
    .mem2proc_data (data1),
    .mem2proc_tag (tag1),
    .mem2proc_err (err1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             nm, obs, exp);
    end
  endtask

  task automatic req(input BUS_COMMAND c,
                     input logic [31:0] a,
                     input MEM_SIZE s,
                     input logic [63:0] d,
                     input logic [7:0] l);
    cmd = c; addr = a; size = s;
    wdata = d; lat = l;
  endtask

  task automatic idle();
    cmd = BUS_NONE; addr = '0;
    wdata = '0; lat = '0;
  endtask

  initial begin
    // reset state
    idle();
    cyc(); cyc();
    chk("rst_resp", 64'(resp0), 0);
    chk("rst_tag", 64'(tag0), 0);
    chk("rst_data", data0, 0);
    chk("rst_err", 64'(err0), 0);
    rst = 1'b0;

    // store then load same line
    req(BUS_STORE, 32'h10, WORD,
        64'hDEADBEEF, 8'd4);
    cyc();
    chk("st_resp", 64'(resp0), 1);
    chk("st_err", 64'(err0), 0);
    req(BUS_LOAD, 32'h10, DOUBLE, 0, 8'd4);
    cyc();
    chk("ld_resp", 64'(resp0), 2);
    idle();
    for (int i = 2; i <= 4; i++) begin
      cyc();
      chk("ld_early", 64'(tag0), 0);
    end
    chk("ack_st_tag", 64'(tag1), 1);
    chk("ack_st_data", data1, 0);
    cyc();
    chk("ld_tag", 64'(tag0), 2);
    chk("ld_data", data0, 64'hDEADBEEF);
    chk("ack_ld_tag", 64'(tag1), 2);
    cyc();
    chk("idle_tag", 64'(tag0), 0);
    chk("idle_data", data0, 0);

    // out-of-order return
    req(BUS_LOAD, 32'h8, DOUBLE, 0, 8'd10);
    cyc();
    chk("ooo_r1", 64'(resp0), 1);
    req(BUS_LOAD, 32'h0, DOUBLE, 0, 8'd1);
    cyc();
    chk("ooo_r2", 64'(resp0), 2);
    idle();
    cyc();
    chk("ooo_first", 64'(tag0), 2);
    for (int i = 3; i <= 10; i++) begin
      cyc();
      chk("ooo_second", 64'(tag0),
          (i == 10) ? 64'd1 : 64'd0);
    end

    // byte merge, and no same-edge reuse of a
    // store tag freeing at that edge
    req(BUS_STORE, 32'h13, BYTE, 64'h5A, 8'd1);
    cyc();
    chk("mrg_st_resp", 64'(resp0), 1);
    req(BUS_LOAD, 32'h10, DOUBLE, 0, 8'd0);
    cyc();
    chk("mrg_ld_resp", 64'(resp0), 2);
    chk("mrg_ack_tag", 64'(tag1), 1);
    idle();
    cyc();
    chk("mrg_tag", 64'(tag0), 2);
    chk("mrg_data", data0, 64'h5AADBEEF);
    chk("mrg_data1", data1, 64'h5AADBEEF);
    req(BUS_LOAD, 32'h11, BYTE, 0, 8'd1);
    cyc();
    chk("byte_resp", 64'(resp0), 1);
    idle();
    cyc();
    chk("byte_tag", 64'(tag0), 1);
    chk("byte_data", data0, 64'hBE);

    // invalid requests
    req(BUS_LOAD, 32'h3, HALF, 0, 8'd1);
    cyc();
    chk("mis_resp", 64'(resp0), 0);
    chk("mis_err", 64'(err0), 1);
    req(BUS_LOAD, 32'(LN * 8), DOUBLE, 0, 8'd1);
    cyc();
    chk("oor_resp", 64'(resp0), 0);
    chk("oor_err", 64'(err0), 1);
    req(BUS_LOAD, 32'(LN * 8 - 8), DOUBLE,
        0, 8'd1);
    cyc();
    chk("top_resp", 64'(resp0), 1);
    chk("top_err", 64'(err0), 0);
    idle();
    cyc();
    chk("top_tag", 64'(tag0), 1);

    // three loads expiring together
    req(BUS_LOAD, 32'h10, DOUBLE, 0, 8'd5);
    cyc();
    chk("tri_r1", 64'(resp0), 1);
    req(BUS_LOAD, 32'h10, DOUBLE, 0, 8'd4);
    cyc();
    chk("tri_r2", 64'(resp0), 2);
    req(BUS_LOAD, 32'h10, DOUBLE, 0, 8'd3);
    cyc();
    chk("tri_r3", 64'(resp0), 3);
    idle();
    cyc(); cyc();
    chk("tri_wait", 64'(tag0), 0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("tri_order", 64'(tag0), 64'(i));
      chk("tri_data", data0, 64'h5AADBEEF);
    end
    cyc();
    chk("tri_done", 64'(tag0), 0);

    // exhaust all tags, then retry
    for (int i = 0; i < NT; i++) begin
      req(BUS_LOAD, 32'(8 * i), DOUBLE,
          0, 8'd20);
      cyc();
      chk("fill_resp", 64'(resp0), 64'(i + 1));
    end
    req(BUS_LOAD, 32'h40, DOUBLE, 0, 8'd20);
    for (int k = NT; k <= 20; k++) begin
      cyc();
      chk("full_resp", 64'(resp0), 0);
      chk("full_err", 64'(err0), 0);
    end
    chk("full_ret", 64'(tag0), 1);
    cyc();
    chk("retry_resp", 64'(resp0), 1);

    // reset with outstanding loads and a request
    rst = 1'b1;
    req(BUS_LOAD, 32'h10, DOUBLE, 0, 8'd1);
    cyc();
    chk("rr_resp", 64'(resp0), 0);
    chk("rr_tag", 64'(tag0), 0);
    cyc();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 25; i++) begin
      cyc();
      chk("rr_stale0", 64'(tag0), 0);
      chk("rr_stale1", 64'(tag1), 0);
    end
    req(BUS_LOAD, 32'h10, DOUBLE, 0, 8'd1);
    cyc();
    chk("rr_new_resp", 64'(resp0), 1);
    idle();
    cyc();
    chk("rr_new_tag", 64'(tag0), 1);
    chk("rr_mem_clr", data0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tagged_mem.md
TAGGED_MEM -- requirements
Module: tagged_mem

Interface
REQ-001 SHALL take parameter NUM_TAGS, default 15, giving the number of outstanding transaction tags, numbered 1..NUM_TAGS; tag 0 means none.
REQ-002 SHALL take parameter LINES, default 8192, giving the memory depth in 64-bit lines.
REQ-003 SHALL take parameter LAT_W, default 8, giving the width of the latency input.
REQ-004 SHALL take parameter STORE_ACK, default 0; when 1, stores also return their tag on the data bus.
REQ-005 SHALL derive TAG_W = $clog2(NUM_TAGS+1) and ADDR_W = XLEN.
REQ-006 Ports SHALL be, in order:
- clk  in  1  the one clock; posedge only
- rst  in  1  reset; synchronous, active-high
- proc2mem_addr  in  ADDR_W  byte address
- proc2mem_data  in  64  store data
- proc2mem_size  in  MEM_SIZE  BYTE/HALF/WORD/DOUBLE
- proc2mem_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE
- mem_latency  in  LAT_W  per-request latency, sampled at accept; 0 is treated as 1
- mem2proc_response  out  TAG_W  accepted tag; 0 means not accepted
- mem2proc_data  out  64  returned data
- mem2proc_tag  out  TAG_W  tag of the returned data; 0 means none
- mem2proc_err  out  1  request rejected as misaligned or out of range

Function
REQ-007 All state SHALL update on posedge clk; all outputs SHALL be registered.
REQ-008 A request is the command BUS_LOAD or BUS_STORE; it SHALL be valid only if the address < LINES*8 and is naturally aligned (HALF: addr[0]=0; WORD: addr[1:0]=0; DOUBLE: addr[2:0]=0).
REQ-009 Invalid request: response=0 and err=1 for one cycle; no memory or tag state changes.
REQ-010 Valid request with a free tag: allocate the lowest-numbered free tag T; response=T the cycle after the sampling edge; err=0.
REQ-011 Valid request with all tags busy: response=0, err=0; the request is dropped and the requester must retry.
REQ-012 Store: memory write at the accept edge; BYTE/HALF/WORD merge into the line at lane addr[2:0]/addr[2:1]/addr[2]; DOUBLE writes all 64 bits.
REQ-013 Load: data captured at the accept edge, post any earlier store; the requested lane is zero-extended to 64 bits; DOUBLE returns the full line.
REQ-014 Each busy tag SHALL hold a countdown loaded with max(mem_latency,1), decremented each edge until 0; at 0 the tag is expired.
REQ-015 A load tag, or a store tag when STORE_ACK=1, SHALL be returned only once expired.
REQ-016 Return: each edge, the lowest-numbered expired tag drives mem2proc_tag and its data (store: data=0); at most one return per cycle.
REQ-017 Unreturned expired tags SHALL wait with no loss; minimum load-to-data latency = L cycles after the response cycle.
REQ-018 With STORE_ACK=0, a store tag SHALL free when its countdown reaches 0, without using the bus.
REQ-019 A tag freed at an edge SHALL NOT be reallocated at that same edge; it is allocatable from the next edge.
REQ-020 Idle bus: mem2proc_tag=0, mem2proc_data=0.
REQ-021 Simultaneous accept and return at one edge SHALL both proceed independently.

Reset
REQ-022 At a rst edge: response=0, tag=0, data=0, err=0; all tags free; countdowns 0; memory lines 0.
REQ-023 Reset mid-operation SHALL abort all outstanding transactions; no stale tag may appear after reset.
REQ-024 A request presented during rst SHALL be ignored.

Structure
REQ-025 MEM_SIZE, the BUS_* command encodings and the per-tag record type {busy, is_load, count, data} SHALL live in the shared sys_defs package.
REQ-026 One sub-module, mem_tag_pick: a parametrised lowest-index priority picker, instantiated twice (free-tag allocation, expired-tag return).

Verification
REQ-027 Reset, then WORD store 0xDEADBEEF @0x10 with L=4, then DOUBLE load @0x10 with L=4 -> responses 1 then 2; tag 2 returns 0x00000000DEADBEEF 4 cycles after its response.
REQ-028 Load @0x8 with L=10 (tag 1), then next cycle load @0x0 with L=1 (tag 2) -> tag 2 returns before tag 1 (out of order).
REQ-029 Issue NUM_TAGS loads with L=20, then one more -> last response=0, err=0; after the first return plus one cycle, a retry is accepted with the freed tag.
REQ-030 HALF load @0x3; load @LINES*8 -> response=0, err=1 in each case; no tag consumed.
REQ-031 Three loads with L=5, 4, 3 on consecutive cycles (all expire together) -> returns on 3 consecutive cycles, ordered tag 1, 2, 3; STORE_ACK=1 run -> stores also return tags with data 0.
REQ-032 rst asserted with 3 outstanding loads -> no tag ever returned; the next request gets tag 1.
